// File: rtl/unary_add_pkg.sv
// Shared types and helpers for the N-input unary adder.
// Holds the FSM state encoding and the ones-count function.
package unary_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT,
        DONE
    } state_t;

    localparam int MAX_IN = 64;

    function automatic int pc_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Zero-extended input; callers narrow the result to pc_width(NUM_IN).
    function automatic int unsigned popcount(
        input logic [MAX_IN-1:0] bits
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_IN; i++) begin
            n = n + 32'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/unary_add_nch_popcount.sv
// Combinational ones-count of the NUM_IN input stream bits.
// Thin wrapper around the package popcount function.
module unary_popcount
    import unary_add_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int PC_W   = pc_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] din,
    output logic [PC_W-1:0]   ones
);

    logic [MAX_IN-1:0] ext;

    always_comb begin
        ext             = '0;
        ext[NUM_IN-1:0] = din;
    end

    assign ones = PC_W'(popcount(ext));

endmodule

// File: rtl/unary_add_nch.sv
// N-input unary adder: counts ones into a saturating accumulator,
// then replays the total as a thermometer stream on dout.
module unary_add_nch
    import unary_add_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              read_or_write,
    input  logic [NUM_IN-1:0] din,
    output logic              dout,
    output logic              C,
    output logic              done,
    output logic              busy,
    output logic [CNT_W-1:0]  count
);

    localparam int PC_W  = pc_width(NUM_IN);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX =
        {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_d;
    logic             c_q;
    logic             c_d;
    logic             dout_q;
    logic             dout_d;
    logic             done_q;
    logic             done_d;

    logic [PC_W-1:0]  ones;
    logic [CNT_W-1:0] acc_base;
    logic [SUM_W-1:0] sum;
    logic             sat;
    logic [CNT_W-1:0] acc_cnt;

    unary_popcount #(
        .NUM_IN (NUM_IN),
        .PC_W   (PC_W)
    ) u_popcount (
        .din  (din),
        .ones (ones)
    );

    // A fresh read phase (from IDLE or DONE) starts from zero.
    assign acc_base = (state_q == ACCUM) ? count_q : '0;
    assign sum = {{(SUM_W-CNT_W){1'b0}}, acc_base}
               + {{(SUM_W-PC_W){1'b0}}, ones};
    assign sat     = (sum > CNT_MAX);
    assign acc_cnt = sat ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        c_d     = c_q;
        rem_d   = rem_q;
        dout_d  = 1'b0;
        done_d  = 1'b0;
        unique case (1'b1)
            (state_q == IDLE),
            (state_q == DONE): begin
                if (!read_or_write) begin
                    state_d = ACCUM;
                    count_d = acc_cnt;
                    c_d     = sat;
                end
            end
            (state_q == ACCUM): begin
                if (read_or_write) begin
                    rem_d   = count_q;
                    state_d = EMIT;
                end else begin
                    count_d = acc_cnt;
                    c_d     = c_q | sat;
                end
            end
            (state_q == EMIT): begin
                if (rem_q != '0) begin
                    dout_d = 1'b1;
                    rem_d  = rem_q - CNT_W'(1);
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            c_q     <= 1'b0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            c_q     <= c_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end else begin
            done_q  <= 1'b0;
        end
    end

    assign dout  = dout_q;
    assign C     = c_q;
    assign done  = done_q;
    assign busy  = (state_q == EMIT);
    assign count = count_q;

endmodule

// File: tb/tb_unary_add_nch.sv
// Bench for unary_add_nch: two configurations, directed scenarios
// plus random traffic, checked every cycle against a behavioural model.
module tb_unary_add_nch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, rw;
    logic [1:0] din;
    logic       dout, c2, done, busy;
    logic [4:0] count;

    logic       rst4, en4, rw4;
    logic [3:0] din4;
    logic       dout4, c4, done4, busy4;
    logic [2:0] count4;

    unary_add_nch #(.NUM_IN(2), .CNT_W(5)) u_dut (
        .clk(clk), .rst(rst), .en(en), .read_or_write(rw), .din(din),
        .dout(dout), .C(c2), .done(done), .busy(busy), .count(count)
    );

    unary_add_nch #(.NUM_IN(4), .CNT_W(3)) u_dut4 (
        .clk(clk), .rst(rst4), .en(en4), .read_or_write(rw4), .din(din4),
        .dout(dout4), .C(c4), .done(done4), .busy(busy4), .count(count4)
    );

    // phase: 0 waiting, 1 reading, 2 emitting, 3 finished
    typedef struct {
        int ph;
        int cnt;
        bit c;
        int rem;
        bit dout;
        bit done;
    } mdl_t;

    mdl_t m2, m4;
    int total = 0;
    int bad = 0;
    bit armed = 0;
    bit len2, len4;
    int hi2 = 0, hi4 = 0, dn2 = 0, dn4 = 0, bz2 = 0;

    function automatic mdl_t nxt(mdl_t m, bit r, bit e, bit w,
                                 int ones, int mx);
        mdl_t n;
        n = m;
        if (r) begin
            n.ph = 0; n.cnt = 0; n.c = 0;
            n.rem = 0; n.dout = 0; n.done = 0;
        end else if (!e) begin
            n.done = 0;
        end else begin
            n.done = 0;
            n.dout = 0;
            if (m.ph == 0 || m.ph == 3) begin
                if (!w) begin
                    n.ph = 1;
                    n.cnt = (ones > mx) ? mx : ones;
                    n.c = (ones > mx);
                end
            end else if (m.ph == 1) begin
                if (w) begin
                    n.rem = m.cnt;
                    n.ph = 2;
                end else if (m.cnt + ones > mx) begin
                    n.cnt = mx;
                    n.c = 1;
                end else begin
                    n.cnt = m.cnt + ones;
                end
            end else begin
                if (m.rem > 0) begin
                    n.dout = 1;
                    n.rem = m.rem - 1;
                end else begin
                    n.done = 1;
                    n.ph = 3;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m2 = nxt(m2, rst, en, rw, $countones(din), 31);
        m4 = nxt(m4, rst4, en4, rw4, $countones(din4), 7);
        len2 = en && !rst;
        len4 = en4 && !rst4;
        armed = 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("dout2", 32'(dout), 32'(m2.dout));
            chk("c2", 32'(c2), 32'(m2.c));
            chk("done2", 32'(done), 32'(m2.done));
            chk("busy2", 32'(busy), 32'(m2.ph == 2));
            chk("count2", 32'(count), 32'(m2.cnt));
            chk("dout4", 32'(dout4), 32'(m4.dout));
            chk("c4", 32'(c4), 32'(m4.c));
            chk("done4", 32'(done4), 32'(m4.done));
            chk("busy4", 32'(busy4), 32'(m4.ph == 2));
            chk("count4", 32'(count4), 32'(m4.cnt));
            if (dout === 1'b1 && len2) hi2++;
            if (dout4 === 1'b1 && len4) hi4++;
            if (done === 1'b1) dn2++;
            if (done4 === 1'b1) dn4++;
            if (busy === 1'b1) bz2++;
        end
    end

    task automatic cyc(input logic e, input logic w, input logic [1:0] d);
        @(negedge clk);
        #1;
        en = e; rw = w; din = d;
    endtask

    task automatic cyc4(input logic e, input logic w, input logic [3:0] d);
        @(negedge clk);
        #1;
        en4 = e; rw4 = w; din4 = d;
    endtask

    task automatic emit(input int which, input int budget);
        int start, n;
        start = (which == 2) ? dn2 : dn4;
        n = 0;
        while (((which == 2) ? dn2 : dn4) == start && n < budget) begin
            if (which == 2) cyc(1, 1, 0);
            else cyc4(1, 1, 0);
            n++;
        end
        chk("emit_timeout", 32'(((which == 2) ? dn2 : dn4) != start), 1);
        repeat (3) begin
            if (which == 2) cyc(1, 1, 0);
            else cyc4(1, 1, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; en = 0; rw = 0; din = 0;
        rst4 = 1; en4 = 0; rw4 = 1; din4 = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_c", 32'(c2), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dout", 32'(dout), 0);
        rst = 0; rst4 = 0;

        // saturation run
        hi2 = 0; dn2 = 0;
        repeat (19) cyc(1, 0, 2'b11);
        emit(2, 60);
        chk("t1_count", 32'(count), 31);
        chk("t1_c", 32'(c2), 1);
        chk("t1_hi", 32'(hi2), 31);
        chk("t1_done", 32'(dn2), 1);

        // mixed stream, total 6
        hi2 = 0; dn2 = 0;
        cyc(1, 0, 2'b11); cyc(1, 0, 2'b01); cyc(1, 0, 2'b00);
        cyc(1, 0, 2'b10); cyc(1, 0, 2'b11);
        emit(2, 40);
        chk("t2_count", 32'(count), 6);
        chk("t2_c", 32'(c2), 0);
        chk("t2_hi", 32'(hi2), 6);

        // empty accumulation
        hi2 = 0; dn2 = 0;
        cyc(1, 0, 2'b00);
        @(negedge clk);
        bz2 = 0;
        #1;
        emit(2, 10);
        chk("t3_hi", 32'(hi2), 0);
        chk("t3_busy", 32'(bz2), 1);
        chk("t3_done", 32'(dn2), 1);

        // freeze mid-emit
        hi2 = 0; dn2 = 0;
        repeat (4) cyc(1, 0, 2'b11);
        repeat (3) cyc(1, 1, 2'b00);
        repeat (5) cyc(0, 0, 2'b11);
        emit(2, 40);
        chk("t4_hi", 32'(hi2), 8);
        chk("t4_count", 32'(count), 8);

        // reset during emission
        repeat (5) cyc(1, 0, 2'b11);
        repeat (3) cyc(1, 1, 2'b00);
        @(negedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        #1;
        chk("t5_count", 32'(count), 0);
        chk("t5_c", 32'(c2), 0);
        chk("t5_dout", 32'(dout), 0);
        chk("t5_busy", 32'(busy), 0);
        rst = 0;

        // four-channel, three-bit accumulator
        hi4 = 0; dn4 = 0;
        cyc4(1, 0, 4'hF);
        emit(4, 20);
        chk("t6_count", 32'(count4), 4);
        chk("t6_c", 32'(c4), 0);
        chk("t6_hi", 32'(hi4), 4);
        chk("t6_done", 32'(dn4), 1);
        cyc4(1, 0, 4'hF);
        cyc4(1, 0, 4'hF);
        cyc4(0, 1, 4'h0);
        chk("t6_sat_count", 32'(count4), 7);
        chk("t6_sat_c", 32'(c4), 1);

        // random traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            rst = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0) rw = ~rw;
            din = 2'($urandom);
            rst4 = ($urandom_range(0, 199) == 0);
            en4 = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) rw4 = ~rw4;
            din4 = 4'($urandom);
        end
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
